lcd_timing_gen: RTL



---
 rtl/lcd_timing_pkg.sv | 30 +++
 rtl/lcd_axis_counter.sv | 59 +++++
 rtl/lcd_timing_gen.sv | 122 ++++++++++++
 3 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared types and constants for the 480x272 LCD raster timing generator.
// Colour-bar table is used only when LCD_TIMING_PATTERN_EN is defined.
package lcd_timing_pkg;

  localparam int CNT_W     = 10;
  localparam int MAX_TOTAL = 1 << CNT_W;

  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FP     = 2;
  localparam int DEF_H_SYNC   = 41;
  localparam int DEF_H_BP     = 2;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FP     = 2;
  localparam int DEF_V_SYNC   = 10;
  localparam int DEF_V_BP     = 2;

  typedef enum logic [1:0] {
    PH_SYNC,
    PH_BP,
    PH_ACT,
    PH_FP
  } phase_e;

  // {R,G,B} on/off per bar; index 0 is the leftmost (white) bar
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101,
    3'b010, 3'b011, 3'b110, 3'b111
  };

endpackage

// File: rtl/lcd_axis_counter.sv
// One raster axis: position counter plus SYNC/BP/ACT/FP phase decode.
// pos/phase are next-state values so the parent can register them directly.
module lcd_axis_counter
  import lcd_timing_pkg::*;
#(
  parameter int SYNC   = 1,
  parameter int BP     = 1,
  parameter int ACTIVE = 1,
  parameter int FP     = 1
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             step,
  output logic [CNT_W-1:0] pos,
  output phase_e           phase,
  output logic             wrap
);

  localparam int TOTAL = SYNC + BP + ACTIVE + FP;

  if (TOTAL > MAX_TOTAL || SYNC == 0 || BP == 0 ||
      ACTIVE == 0 || FP == 0) begin : g_bad_geom
    $error("lcd_axis_counter: invalid geometry");
  end

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] E_SYN = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] E_BP  = CNT_W'(SYNC + BP);
  localparam logic [CNT_W-1:0] E_ACT = CNT_W'(SYNC + BP + ACTIVE);

  logic [CNT_W-1:0] r_pos;

  assign wrap = step & (r_pos == LAST);

  always_comb begin
    pos = r_pos;
    if (step)
      pos = wrap ? '0 : r_pos + 1'b1;
  end

  always_comb begin
    phase = PH_FP;
    if (pos < E_SYN)
      phase = PH_SYNC;
    else if (pos < E_BP)
      phase = PH_BP;
    else if (pos < E_ACT)
      phase = PH_ACT;
  end

  // Reset parks the axis in FP so the first step lands on 0
  always_ff @(posedge CLK) begin
    if (!nRESET)
      r_pos <= LAST;
    else
      r_pos <= pos;
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// Hsync/Vsync/DE raster generator with active-area coordinates.
// Define LCD_TIMING_PATTERN_EN to add the 8-bar colour test pattern outputs.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             pix_en,
  output logic             Hsync,
  output logic             Vsync,
  output logic             DE,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             line_start,
  output logic             frame_start
`ifdef LCD_TIMING_PATTERN_EN
  ,
  output logic [7:0]       pat_R,
  output logic [7:0]       pat_G,
  output logic [7:0]       pat_B
`endif
);

  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_v_step;
  logic             w_de;
  logic [CNT_W-1:0] w_h_pos;
  logic [CNT_W-1:0] w_v_pos;
  logic [CNT_W-1:0] w_hcnt;
  logic [CNT_W-1:0] w_vcnt;
  phase_e           w_h_ph;
  phase_e           w_v_ph;

  assign w_v_step = pix_en & w_h_wrap;

  lcd_axis_counter #(
    .SYNC  (H_SYNC),
    .BP    (H_BP),
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP)
  ) u_h (
    .CLK   (CLK),
    .nRESET(nRESET),
    .step  (pix_en),
    .pos   (w_h_pos),
    .phase (w_h_ph),
    .wrap  (w_h_wrap)
  );

  lcd_axis_counter #(
    .SYNC  (V_SYNC),
    .BP    (V_BP),
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP)
  ) u_v (
    .CLK   (CLK),
    .nRESET(nRESET),
    .step  (w_v_step),
    .pos   (w_v_pos),
    .phase (w_v_ph),
    .wrap  (w_v_wrap)
  );

  assign w_de   = (w_h_ph == PH_ACT) && (w_v_ph == PH_ACT);
  assign w_hcnt = w_de ? w_h_pos - CNT_W'(H_SYNC + H_BP) : '0;
  assign w_vcnt = (w_v_ph == PH_ACT) ?
                  w_v_pos - CNT_W'(V_SYNC + V_BP) : '0;

  // Wrap strobes already carry pix_en, so the pulses drop when disabled
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      Hsync       <= 1'b1;
      Vsync       <= 1'b1;
      DE          <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= w_h_wrap;
      frame_start <= w_v_wrap;
      if (pix_en) begin
        Hsync <= (w_h_ph != PH_SYNC);
        Vsync <= (w_v_ph != PH_SYNC);
        DE    <= w_de;
        hcnt  <= w_hcnt;
        vcnt  <= w_vcnt;
      end
    end
  end

`ifdef LCD_TIMING_PATTERN_EN
  logic [2:0] w_bar;
  logic [2:0] w_rgb;

  assign w_bar = 3'(w_hcnt / CNT_W'(H_ACTIVE / 8));
  assign w_rgb = BAR_RGB[w_bar];

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      pat_R <= 8'h00;
      pat_G <= 8'h00;
      pat_B <= 8'h00;
    end else if (pix_en) begin
      pat_R <= (w_de && w_rgb[2]) ? 8'hFF : 8'h00;
      pat_G <= (w_de && w_rgb[1]) ? 8'hFF : 8'h00;
      pat_B <= (w_de && w_rgb[0]) ? 8'hFF : 8'h00;
    end
  end
`endif

endmodule
